lutram_readback_checker: RTL and testbench

- Consumes the read phase of a LUTRAM primitive test: the per-address read samples (SPO/DPO lanes) that the write/read sequencer produces.
- Compares each sample against the expected pattern and tracks the address order.
- Reports pass/fail, the mismatch count, the first failing address and which lanes failed.
- Sits between the RAM DUT outputs and the board status pins or LEDs, in the same clock domain as the sequencer's read strobe.

---
 rtl/lutram_readback_checker_if.sv | 44 ++++
 rtl/lutram_readback_checker.sv | 105 ++++++++++
 tb/tb_lutram_readback_checker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lutram_readback_checker_if.sv
// lutram_readback_checker_if
//   Bundles the read-sample stream coming from the LUTRAM test sequencer and
//   the status outputs of the readback checker.
//   Handshake: a sample is transferred on every rising clk edge where
//   valid_i is high while the checker is in CHECK. There is no ready; the
//   checker always accepts. start_i is a one-cycle pulse. mode_i is sampled
//   on that same cycle.
//   Ports (slave = checker view):
//     inputs : start_i, mode_i, valid_i, addr_i[A_WIDTH], q_i[D_WIDTH]
//     outputs: busy_o, done_o, pass_o, err_cnt_o[ERR_W], seq_err_o,
//              first_err_valid_o, first_err_addr_o[A_WIDTH],
//              err_lane_o[D_WIDTH], dbg_state_o[2] (FSM state for checkers)
interface lutram_readback_checker_if #(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 2,
  parameter int ERR_W   = 8
);
  logic               start_i;
  logic               mode_i;
  logic               valid_i;
  logic [A_WIDTH-1:0] addr_i;
  logic [D_WIDTH-1:0] q_i;
  logic               busy_o;
  logic               done_o;
  logic               pass_o;
  logic [ERR_W-1:0]   err_cnt_o;
  logic               seq_err_o;
  logic               first_err_valid_o;
  logic [A_WIDTH-1:0] first_err_addr_o;
  logic [D_WIDTH-1:0] err_lane_o;
  logic [1:0]         dbg_state_o;

  modport slave (
    input  start_i, mode_i, valid_i, addr_i, q_i,
    output busy_o, done_o, pass_o, err_cnt_o, seq_err_o,
           first_err_valid_o, first_err_addr_o, err_lane_o, dbg_state_o
  );

  modport master (
    output start_i, mode_i, valid_i, addr_i, q_i,
    input  busy_o, done_o, pass_o, err_cnt_o, seq_err_o,
           first_err_valid_o, first_err_addr_o, err_lane_o, dbg_state_o
  );
endinterface

// File: rtl/lutram_readback_checker.sv
// lutram_readback_checker
//   Checks the read phase of a LUTRAM primitive test. Each accepted sample is
//   compared against the pattern implied by the expected address (all zero,
//   or every lane equal to exp_addr[0]) and the address order is tracked.
//   Ports:
//     clk_i  : single clock, rising edge
//     rst_ni : asynchronous active-low reset
//     bus    : lutram_readback_checker_if.slave (sample stream + results)
//   State encoding on dbg_state_o: 0 = IDLE, 1 = CHECK, 2 = DONE.
module lutram_readback_checker #(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 2,
  parameter int ERR_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  lutram_readback_checker_if.slave     bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic               r_mode;
  logic [A_WIDTH-1:0] r_exp_addr;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_seq_err;
  logic               r_first_valid;
  logic [A_WIDTH-1:0] r_first_addr;
  logic [D_WIDTH-1:0] r_err_lane;

  logic [D_WIDTH-1:0] w_exp_data;
  logic [D_WIDTH-1:0] w_mism;
  logic               w_last;
  logic               w_take;

  // Expected data comes from the internal address counter, never from addr_i,
  // so a misordered address also shows up as a data error when parity differs.
  assign w_exp_data = {D_WIDTH{r_mode & r_exp_addr[0]}};
  assign w_mism     = bus.q_i ^ w_exp_data;
  assign w_last     = &r_exp_addr;
  assign w_take     = (r_state == ST_CHECK) && bus.valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_mode        <= 1'b0;
      r_exp_addr    <= '0;
      r_err_cnt     <= '0;
      r_seq_err     <= 1'b0;
      r_first_valid <= 1'b0;
      r_first_addr  <= '0;
      r_err_lane    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // Arming wins over a coincident valid_i; that sample is dropped.
          if (bus.start_i) begin
            r_state       <= ST_CHECK;
            r_mode        <= bus.mode_i;
            r_exp_addr    <= '0;
            r_err_cnt     <= '0;
            r_seq_err     <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_addr  <= '0;
            r_err_lane    <= '0;
          end
        end
        ST_CHECK: begin
          // start_i is deliberately ignored here.
          if (w_take) begin
            if (w_mism != '0) begin
              if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_W'(1);
              r_err_lane <= r_err_lane | w_mism;
              if (!r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_addr  <= r_exp_addr;
              end
            end
            if (bus.addr_i != r_exp_addr) r_seq_err <= 1'b1;
            if (w_last) begin
              r_state    <= ST_DONE;
              r_exp_addr <= '0;
            end else begin
              r_exp_addr <= r_exp_addr + A_WIDTH'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o            = (r_state == ST_CHECK);
  assign bus.done_o            = (r_state == ST_DONE);
  assign bus.pass_o            = (r_state == ST_DONE) && (r_err_cnt == '0) && !r_seq_err;
  assign bus.err_cnt_o         = r_err_cnt;
  assign bus.seq_err_o         = r_seq_err;
  assign bus.first_err_valid_o = r_first_valid;
  assign bus.first_err_addr_o  = r_first_addr;
  assign bus.err_lane_o        = r_err_lane;
  assign bus.dbg_state_o       = r_state;

endmodule

// File: tb/tb_lutram_readback_checker.sv
// tb_lutram_readback_checker
//   Drives the same sample stream into two checkers (ERR_W = 8 and ERR_W = 3)
//   and compares their results against a pass-level reference model.
module tb_lutram_readback_checker;
  localparam int AW = 6;
  localparam int DW = 2;
  localparam int N  = 64;
  localparam int RW = 22;  // {pass, seq, fev, faddr[6], lane[2], cnt_a[8], cnt_b[3]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          start, mode, valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] q;

  lutram_readback_checker_if #(.A_WIDTH(AW), .D_WIDTH(DW), .ERR_W(8)) bus_a ();
  lutram_readback_checker_if #(.A_WIDTH(AW), .D_WIDTH(DW), .ERR_W(3)) bus_b ();

  assign bus_a.start_i = start;
  assign bus_a.mode_i  = mode;
  assign bus_a.valid_i = valid;
  assign bus_a.addr_i  = addr;
  assign bus_a.q_i     = q;
  assign bus_b.start_i = start;
  assign bus_b.mode_i  = mode;
  assign bus_b.valid_i = valid;
  assign bus_b.addr_i  = addr;
  assign bus_b.q_i     = q;

  lutram_readback_checker #(.A_WIDTH(AW), .D_WIDTH(DW), .ERR_W(8)) u_dut_a (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_a.slave));
  lutram_readback_checker #(.A_WIDTH(AW), .D_WIDTH(DW), .ERR_W(3)) u_dut_b (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- stimulus tables ----------------
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_q    [N];
  int            s_gap  [N];
  int            mid_start;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q [$];
  logic          e_pass, e_seq, e_fev;
  logic [AW-1:0] e_faddr;
  logic [DW-1:0] e_lane;
  logic [7:0]    e_cnt_a;
  logic [2:0]    e_cnt_b;

  // Pass-level model: sample k is checked against address k.
  task automatic model_pass(input logic m);
    int cnt, first;
    logic seq;
    logic [DW-1:0] lane, e;
    cnt = 0; first = -1; seq = 1'b0; lane = '0;
    for (int k = 0; k < N; k++) begin
      e = (m && (k % 2 == 1)) ? {DW{1'b1}} : '0;
      if (s_q[k] != e) begin
        cnt++;
        lane = lane | (s_q[k] ^ e);
        if (first < 0) first = k;
      end
      if (int'(s_addr[k]) != k) seq = 1'b1;
    end
    exp_q.push_back({(cnt == 0) && !seq, seq, first >= 0,
                     (first >= 0) ? AW'(first) : AW'(0), lane,
                     (cnt > 255) ? 8'd255 : 8'(cnt),
                     (cnt > 7) ? 3'd7 : 3'(cnt)});
  endtask

  task automatic pop_expected();
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got empty queue, need one entry");
      {e_pass, e_seq, e_fev, e_faddr, e_lane, e_cnt_a, e_cnt_b} = '0;
    end else begin
      {e_pass, e_seq, e_fev, e_faddr, e_lane, e_cnt_a, e_cnt_b} = exp_q.pop_front();
    end
  endtask

  // ---------------- drivers ----------------
  task automatic fill_clean(input logic m);
    for (int k = 0; k < N; k++) begin
      s_addr[k] = AW'(k);
      s_q[k]    = (m && (k % 2 == 1)) ? {DW{1'b1}} : '0;
      s_gap[k]  = $urandom_range(0, 2);
    end
    mid_start = -1;
  endtask

  task automatic arm(input logic m);
    @(negedge clk);
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom);
  endtask

  task automatic send_samples(input int count);
    for (int k = 0; k < count; k++) begin
      repeat (s_gap[k]) @(negedge clk);
      valid = 1'b1; addr = s_addr[k]; q = s_q[k];
      start = (k == mid_start);
      mode  = 1'($urandom);
      @(negedge clk);
      valid = 1'b0; start = 1'b0;
      addr = AW'($urandom); q = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; mode = 1'b0; valid = 1'b0; addr = '0; q = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (bus_a.busy_o !== 1'b0 || bus_a.done_o !== 1'b0 || bus_a.pass_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b done=%b pass=%b, need 0 0 0", bus_a.busy_o, bus_a.done_o, bus_a.pass_o); end
    n_checks++; if (bus_a.err_cnt_o !== 8'd0 || bus_a.seq_err_o !== 1'b0 || bus_a.first_err_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stats: got cnt=%0d seq=%b fev=%b, need 0 0 0", bus_a.err_cnt_o, bus_a.seq_err_o, bus_a.first_err_valid_o); end
    n_checks++; if (bus_a.first_err_addr_o !== 6'd0 || bus_a.err_lane_o !== 2'b00 || bus_a.dbg_state_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_misc: got faddr=%0d lane=%b state=%0d, need 0 0 0", bus_a.first_err_addr_o, bus_a.err_lane_o, bus_a.dbg_state_o); end
  endtask

  task automatic test_clean_pass();
    fill_clean(1'b1);
    model_pass(1'b1);
    arm(1'b1);
    n_checks++; if (bus_a.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL clean_busy_after_arm: got %b, need 1", bus_a.busy_o); end
    send_samples(N - 1);
    n_checks++; if (bus_a.done_o !== 1'b0) begin
      n_fail++; $display("FAIL clean_done_early: got %b, need 0", bus_a.done_o); end
    send_samples_last();
    pop_expected();
    n_checks++; if (bus_a.done_o !== 1'b1 || bus_a.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL clean_done: got done=%b busy=%b, need 1 0", bus_a.done_o, bus_a.busy_o); end
    n_checks++; if (bus_a.pass_o !== e_pass || e_pass !== 1'b1) begin
      n_fail++; $display("FAIL clean_pass: got %b, need 1", bus_a.pass_o); end
    n_checks++; if (bus_a.err_cnt_o !== 8'd0 || bus_a.err_lane_o !== 2'b00) begin
      n_fail++; $display("FAIL clean_stats: got cnt=%0d lane=%b, need 0 00", bus_a.err_cnt_o, bus_a.err_lane_o); end
    // Results hold in DONE while further valid_i pulses are ignored.
    s_gap[0] = 0; s_addr[0] = 6'd0; s_q[0] = 2'b11; mid_start = -1;
    send_samples(1);
    n_checks++; if (bus_a.done_o !== 1'b1 || bus_a.err_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL done_hold: got done=%b cnt=%0d, need 1 0", bus_a.done_o, bus_a.err_cnt_o); end
  endtask

  // Sends only the final table entry (index N-1).
  task automatic send_samples_last();
    repeat (s_gap[N-1]) @(negedge clk);
    valid = 1'b1; addr = s_addr[N-1]; q = s_q[N-1];
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_data_errors();
    fill_clean(1'b0);
    s_q[5] = 2'b01; s_q[40] = 2'b11;
    model_pass(1'b0);
    arm(1'b0);
    send_samples(N);
    pop_expected();
    n_checks++; if (bus_a.err_cnt_o !== e_cnt_a || bus_a.err_cnt_o !== 8'd2) begin
      n_fail++; $display("FAIL data_err_cnt: got %0d, need 2", bus_a.err_cnt_o); end
    n_checks++; if (bus_a.first_err_addr_o !== 6'd5 || bus_a.first_err_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL data_first: got addr=%0d valid=%b, need 5 1", bus_a.first_err_addr_o, bus_a.first_err_valid_o); end
    n_checks++; if (bus_a.err_lane_o !== 2'b11 || bus_a.pass_o !== 1'b0 || bus_a.done_o !== 1'b1) begin
      n_fail++; $display("FAIL data_lane_pass: got lane=%b pass=%b done=%b, need 11 0 1", bus_a.err_lane_o, bus_a.pass_o, bus_a.done_o); end
  endtask

  task automatic test_seq_error();
    fill_clean(1'b1);
    s_addr[11] = 6'd10; s_q[11] = 2'b00;  // correct data for addr 10
    model_pass(1'b1);
    arm(1'b1);
    send_samples(N);
    pop_expected();
    n_checks++; if (bus_a.seq_err_o !== 1'b1 || bus_a.pass_o !== 1'b0) begin
      n_fail++; $display("FAIL seq_flag: got seq=%b pass=%b, need 1 0", bus_a.seq_err_o, bus_a.pass_o); end
    n_checks++; if (bus_a.err_cnt_o !== 8'd1 || bus_a.first_err_addr_o !== 6'd11 || bus_a.err_lane_o !== e_lane) begin
      n_fail++; $display("FAIL seq_data: got cnt=%0d faddr=%0d lane=%b, need 1 11 %b", bus_a.err_cnt_o, bus_a.first_err_addr_o, bus_a.err_lane_o, e_lane); end
  endtask

  task automatic test_saturation();
    fill_clean(1'b1);
    for (int k = 0; k < N; k++) s_q[k] = ~s_q[k];
    model_pass(1'b1);
    arm(1'b1);
    send_samples(N);
    pop_expected();
    n_checks++; if (bus_b.err_cnt_o !== 3'd7 || e_cnt_b !== 3'd7) begin
      n_fail++; $display("FAIL sat_cnt_w3: got %0d, need 7", bus_b.err_cnt_o); end
    n_checks++; if (bus_a.err_cnt_o !== 8'd64 || bus_a.first_err_addr_o !== 6'd0) begin
      n_fail++; $display("FAIL sat_cnt_w8: got cnt=%0d faddr=%0d, need 64 0", bus_a.err_cnt_o, bus_a.first_err_addr_o); end
  endtask

  task automatic test_async_reset();
    fill_clean(1'b0);
    for (int k = 0; k < N; k++) s_q[k] = 2'b10;
    arm(1'b0);
    send_samples(30);
    n_checks++; if (bus_a.busy_o !== 1'b1 || bus_a.err_cnt_o !== 8'd30) begin
      n_fail++; $display("FAIL mid_pass: got busy=%b cnt=%0d, need 1 30", bus_a.busy_o, bus_a.err_cnt_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus_a.busy_o !== 1'b0 || bus_a.err_cnt_o !== 8'd0 || bus_a.err_lane_o !== 2'b00 || bus_a.first_err_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL async_clear: got busy=%b cnt=%0d lane=%b fev=%b, need 0 0 00 0", bus_a.busy_o, bus_a.err_cnt_o, bus_a.err_lane_o, bus_a.first_err_valid_o); end
    @(negedge clk);
    rst_n = 1'b1;
    mid_start = -1;
    for (int k = 0; k < 5; k++) begin s_gap[k] = k % 2; s_addr[k] = 6'd7; end
    send_samples(5);
    repeat (2) @(negedge clk);
    n_checks++; if (bus_a.busy_o !== 1'b0 || bus_a.done_o !== 1'b0 || bus_a.err_cnt_o !== 8'd0 || bus_a.seq_err_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignores_valid: got busy=%b done=%b cnt=%0d seq=%b, need 0 0 0 0", bus_a.busy_o, bus_a.done_o, bus_a.err_cnt_o, bus_a.seq_err_o); end
    fill_clean(1'b1);
    model_pass(1'b1);
    arm(1'b1);
    send_samples(N);
    pop_expected();
    n_checks++; if (bus_a.pass_o !== e_pass || bus_a.done_o !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_pass: got pass=%b done=%b, need %b 1", bus_a.pass_o, bus_a.done_o, e_pass); end
  endtask

  task automatic test_rearm_coincident();
    // Leave the block in DONE with stale errors first.
    fill_clean(1'b0);
    s_q[3] = 2'b10; s_addr[9] = 6'd1;
    arm(1'b0);
    send_samples(N);
    n_checks++; if (bus_a.err_cnt_o !== 8'd1 || bus_a.seq_err_o !== 1'b1 || bus_a.done_o !== 1'b1) begin
      n_fail++; $display("FAIL stale_setup: got cnt=%0d seq=%b done=%b, need 1 1 1", bus_a.err_cnt_o, bus_a.seq_err_o, bus_a.done_o); end
    @(negedge clk);
    start = 1'b1; mode = 1'b1; valid = 1'b1; addr = 6'd5; q = 2'b11;
    @(negedge clk);
    start = 1'b0; valid = 1'b0; mode = 1'b0;
    n_checks++; if (bus_a.busy_o !== 1'b1 || bus_a.err_cnt_o !== 8'd0 || bus_a.seq_err_o !== 1'b0 ||
                    bus_a.first_err_valid_o !== 1'b0 || bus_a.err_lane_o !== 2'b00 || bus_a.first_err_addr_o !== 6'd0) begin
      n_fail++; $display("FAIL rearm_clear: got busy=%b cnt=%0d seq=%b fev=%b lane=%b faddr=%0d, need 1 0 0 0 00 0",
        bus_a.busy_o, bus_a.err_cnt_o, bus_a.seq_err_o, bus_a.first_err_valid_o, bus_a.err_lane_o, bus_a.first_err_addr_o); end
    fill_clean(1'b1);
    mid_start = 20;
    model_pass(1'b1);
    send_samples(N);
    pop_expected();
    n_checks++; if (bus_a.pass_o !== e_pass || e_pass !== 1'b1 || bus_a.done_o !== 1'b1) begin
      n_fail++; $display("FAIL rearm_pass: got pass=%b done=%b, need 1 1", bus_a.pass_o, bus_a.done_o); end
  endtask

  task automatic test_random();
    logic m;
    for (int it = 0; it < 4; it++) begin
      m = 1'($urandom);
      fill_clean(m);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) s_q[k] = DW'($urandom);
        if ($urandom_range(0, 29) == 0) s_addr[k] = AW'($urandom);
      end
      if (it == 3) for (int k = 0; k < N; k++) s_q[k] = DW'($urandom);
      model_pass(m);
      arm(m);
      send_samples(N);
      pop_expected();
      n_checks++; if (bus_a.done_o !== 1'b1 || bus_a.pass_o !== e_pass || bus_a.seq_err_o !== e_seq) begin
        n_fail++; $display("FAIL rand%0d_flags: got done=%b pass=%b seq=%b, need 1 %b %b", it, bus_a.done_o, bus_a.pass_o, bus_a.seq_err_o, e_pass, e_seq); end
      n_checks++; if (bus_a.err_cnt_o !== e_cnt_a || bus_b.err_cnt_o !== e_cnt_b) begin
        n_fail++; $display("FAIL rand%0d_cnt: got a=%0d b=%0d, need %0d %0d", it, bus_a.err_cnt_o, bus_b.err_cnt_o, e_cnt_a, e_cnt_b); end
      n_checks++; if (bus_a.first_err_valid_o !== e_fev || bus_a.first_err_addr_o !== e_faddr || bus_a.err_lane_o !== e_lane) begin
        n_fail++; $display("FAIL rand%0d_first: got fev=%b faddr=%0d lane=%b, need %b %0d %b", it,
          bus_a.first_err_valid_o, bus_a.first_err_addr_o, bus_a.err_lane_o, e_fev, e_faddr, e_lane); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_clean_pass();
    test_data_errors();
    test_seq_error();
    test_saturation();
    test_async_reset();
    test_rearm_coincident();
    test_random();
    n_checks++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left, need 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end
endmodule
